pipeline_skid_stage: RTL
========================

Name: pipeline_skid_stage

Overview:
- Next-generation inter-stage pipeline register: one parametrised-width bundle per instance, in place of one flop per field.
- Replaces the stall_current_stage/stall_next_stage convention with a valid/ready handshake, optional 2-entry skid buffer, and synchronous flush with configurable bubble value.
- Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB); fields are concatenated into data_in by the wrapper.
- Legacy mapping: out_ready = !stall_next_stage; in_valid = !stall_current_stage.

Parameters:
- DATA_WIDTH, 32, width of the bundled payload.
- RESET_VALUE, {DATA_WIDTH{1'b0}}, payload value held by empty or flushed entries (the bubble value).
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous clear of all entries, highest priority.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept this cycle.
- data_in  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  data_out holds a live payload.
- out_ready  input  1  downstream accepts this cycle.
- data_out  output  DATA_WIDTH  payload to the next stage.
- occupancy  output  2  live entries, range 0..2.

Behaviour:
- Transfer definitions: accept = in_valid & in_ready & !flush; emit = out_valid & out_ready.
- Reset (rst low, asynchronous): main and skid entries invalid. Both data registers = RESET_VALUE. out_valid=0, data_out=RESET_VALUE, occupancy=0, in_ready=1.
- State encoding: EMPTY (occ 0), BUSY (main valid, occ 1), FULL (main+skid valid, occ 2). FULL exists only when SKID_EN=1.
- SKID_EN=1 outputs:
  - in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - out_valid = main_valid; data_out = main_data.
- SKID_EN=1 transitions (evaluated when flush=0):
  - EMPTY, accept -> BUSY, main<=data_in.
  - BUSY, accept & emit -> BUSY, main<=data_in.
  - BUSY, accept & !emit -> FULL, skid<=data_in.
  - BUSY, !accept & emit -> EMPTY, main<=RESET_VALUE.
  - FULL, emit -> BUSY, main<=skid, skid<=RESET_VALUE. No accept is possible in FULL.
  - Any other combination -> hold state and data.
- SKID_EN=0 behaviour:
  - in_ready = !main_valid | out_ready, combinational.
  - Accept always loads main. Emit without accept -> EMPTY with main<=RESET_VALUE.
  - Sustains 1 transfer/cycle.
- Flush:
  - Next state EMPTY, both data registers <= RESET_VALUE, regardless of in_valid or out_ready.
  - An input presented in the flush cycle is dropped.
  - An output emitted in the flush cycle counts as consumed.
  - in_ready has no combinational dependence on flush.
- Invariants:
  - Latency is 1 cycle from accept to out_valid when the stage was EMPTY or emitting.
  - Order is strictly FIFO; no payload is duplicated or lost without a flush.
  - data_out == RESET_VALUE whenever out_valid=0, which preserves bubble semantics for downstream decode.
  - data_out and out_valid are stable while out_valid=1 & out_ready=0.
- Reset mid-operation: all entries cleared immediately, without waiting for a clock edge. The first accept after release behaves as from EMPTY.
- occupancy = main_valid + skid_valid.

Decomposition:
- Shared header beside bus.v: state encodings STAGE_EMPTY/STAGE_BUSY/STAGE_FULL (2 bits) and STAGE_OCC_WIDTH.
- Existing *_BUS_WIDTH macros size DATA_WIDTH at the wrapper.
- One sub-module: stage_entry_reg.
  - Holds one payload plus its valid bit, with load, clear-to-RESET_VALUE, and async active-low reset.
  - Instantiated as main and skid. The skid instance is generated only when SKID_EN=1.

Test Plan:
- Reset: hold rst=0 with in_valid=1, data_in=32'hDEAD_BEEF -> out_valid=0, data_out=0, in_ready=1, occupancy=0. Release rst -> first accept appears at out after 1 cycle.
- Streaming, out_ready=1: 32'h11, 32'h22, 32'h33 on consecutive cycles -> data_out shows 11, 22, 33 on the next three cycles, in_ready stays 1, occupancy stays 1.
- Backpressure, SKID_EN=1, out_ready=0: send 32'hA then 32'hB -> occupancy=2, in_ready=0, and 32'hC is held upstream. Raise out_ready -> outputs A, B, C in order with no gaps or loss.
- Flush in FULL with in_valid=1, data_in=32'hFF -> next cycle out_valid=0, data_out=RESET_VALUE, occupancy=0, in_ready=1, and 32'hFF never appears.
- SKID_EN=0, main full, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 with in_valid=1 -> one transfer per cycle, with data_out following data_in by 1 cycle.
- Async reset mid-FULL: drop rst between clock edges -> out_valid, occupancy, and data_out clear before the next edge, and no held payload is emitted after release.

Source files
------------

// File: rtl/pipeline_skid_stage_pkg.sv
// Shared definitions for the inter-stage pipeline register: state encodings,
// occupancy width and the per-entry control bundle.
package pipeline_skid_stage_pkg;

   localparam int unsigned STAGE_OCC_WIDTH = 2;

   typedef enum logic [1:0] {
      STAGE_EMPTY = 2'd0,
      STAGE_BUSY  = 2'd1,
      STAGE_FULL  = 2'd2
   } stage_state_e;

   typedef struct packed {
      logic load;
      logic clear;
   } entry_ctrl_t;

endpackage : pipeline_skid_stage_pkg

// File: rtl/pipeline_skid_stage_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// master = surrounding core logic, slave = the stage register.
interface pipeline_skid_stage_if
   import pipeline_skid_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                       flush;
   logic                       in_valid;
   logic                       in_ready;
   logic [DATA_WIDTH-1:0]      data_in;
   logic                       out_valid;
   logic                       out_ready;
   logic [DATA_WIDTH-1:0]      data_out;
   logic [STAGE_OCC_WIDTH-1:0] occupancy;

   modport master (
      output flush, in_valid, data_in, out_ready,
      input  in_ready, out_valid, data_out, occupancy
   );

   modport slave (
      input  flush, in_valid, data_in, out_ready,
      output in_ready, out_valid, data_out, occupancy
   );
endinterface : pipeline_skid_stage_if

// File: rtl/pipeline_skid_stage_entry_reg.sv
// stage_entry_reg: one payload plus valid bit, with load and clear-to-bubble.
// Clear wins over load.
module pipeline_skid_stage_entry_reg
   import pipeline_skid_stage_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  entry_ctrl_t           ctrl,
   input  logic [DATA_WIDTH-1:0] d,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         q     <= RESET_VALUE;
      end else if (ctrl.clear) begin
         valid <= 1'b0;
         q     <= RESET_VALUE;
      end else if (ctrl.load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule : pipeline_skid_stage_entry_reg

// File: rtl/pipeline_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer and synchronous flush to a configurable bubble value.
module pipeline_skid_stage
   import pipeline_skid_stage_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
   parameter bit                    SKID_EN     = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_skid_stage_if.slave   bus
);

   stage_state_e          state_q;
   stage_state_e          state_d;
   entry_ctrl_t           main_ctrl;
   entry_ctrl_t           skid_ctrl;
   logic [DATA_WIDTH-1:0] main_d;
   logic [DATA_WIDTH-1:0] main_data;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  main_valid;
   logic                  skid_valid;
   logic                  in_ready_c;
   logic                  accept;
   logic                  emit;

   // With the skid entry, in_ready depends only on flops; without it, a full
   // main entry can still take a new payload in the cycle it drains.
   assign in_ready_c = SKID_EN ? !skid_valid : (!main_valid || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c && !bus.flush;
   assign emit       = main_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= STAGE_EMPTY;
      else      state_q <= state_d;
   end

   // Next-state and entry control
   always_comb begin
      state_d   = state_q;
      main_ctrl = '0;
      skid_ctrl = '0;
      main_d    = bus.data_in;
      if (bus.flush) begin
         state_d         = STAGE_EMPTY;
         main_ctrl.clear = 1'b1;
         skid_ctrl.clear = 1'b1;
      end else begin
         unique case (state_q)
            STAGE_EMPTY: begin
               if (accept) begin
                  state_d        = STAGE_BUSY;
                  main_ctrl.load = 1'b1;
               end
            end
            STAGE_BUSY: begin
               if (accept && emit) begin
                  main_ctrl.load = 1'b1;
               end else if (accept && SKID_EN) begin
                  state_d        = STAGE_FULL;
                  skid_ctrl.load = 1'b1;
               end else if (emit) begin
                  state_d         = STAGE_EMPTY;
                  main_ctrl.clear = 1'b1;
               end
            end
            STAGE_FULL: begin
               if (emit) begin
                  state_d         = STAGE_BUSY;
                  main_d          = skid_data;
                  main_ctrl.load  = 1'b1;
                  skid_ctrl.clear = 1'b1;
               end
            end
            default: begin
               state_d         = STAGE_EMPTY;
               main_ctrl.clear = 1'b1;
               skid_ctrl.clear = 1'b1;
            end
         endcase
      end
   end

   pipeline_skid_stage_entry_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .ctrl  (main_ctrl),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_data)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipeline_skid_stage_entry_reg #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
         ) u_skid (
            .clk   (clk),
            .rst   (rst),
            .ctrl  (skid_ctrl),
            .d     (bus.data_in),
            .valid (skid_valid),
            .q     (skid_data)
         );
      end else begin : g_no_skid
         logic unused_skid_ctrl;
         assign unused_skid_ctrl = ^skid_ctrl;
         assign skid_valid       = 1'b0;
         assign skid_data        = RESET_VALUE;
      end
   endgenerate

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = main_valid;
   assign bus.data_out  = main_data;
   assign bus.occupancy = STAGE_OCC_WIDTH'(main_valid) + STAGE_OCC_WIDTH'(skid_valid);

endmodule : pipeline_skid_stage
